// File: rtl/spi_sta_responder.sv
// SPI mode-3 responder for the SPI_STA boot link: captures a command frame from MOSI and
// shifts a pre-loaded response back on MISO. All logic runs on spi_clk_i using synchronised pins.
module spi_sta_responder #(
    parameter int CMD_W       = 48,
    parameter int RSP_W       = 80,
    parameter int SYNC_STAGES = 2
) (
    input  logic             spi_clk_i,
    input  logic             spi_rst_i,
    input  logic             SCK,
    input  logic             SS,
    input  logic             MOSI,
    output logic             MISO,
    input  logic             spi_fbo_i,
    output logic [CMD_W-1:0] cmd_data_o,
    output logic             cmd_valid_o,
    input  logic [RSP_W-1:0] rsp_data_i,
    input  logic             rsp_load_i,
    output logic             rsp_busy_o,
    output logic             frame_err_o
);

    // IDLE wait for SS | CMD shift command in | WAIT filler until response | RESP shift out | DONE hold
    typedef enum logic [2:0] {IDLE, CMD, WAIT, RESP, DONE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
    logic                   sck_d, ss_d;
    logic [7:0]             cnt;
    logic [CMD_W-1:0]       cmd_sr, cmd_next;
    logic [RSP_W-1:0]       rsp_buf, rsp_sr, rsp_src;
    logic                   sck_s, ss_s, mosi_s;
    logic                   rise, fall, ss_rise, ss_fall, load_ok;

    always_ff @(posedge spi_clk_i or negedge spi_rst_i) begin
        if (!spi_rst_i) begin
            sck_sync  <= '1;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b1;
            ss_d      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            sck_d     <= sck_sync[SYNC_STAGES-1];
            ss_d      <= ss_sync[SYNC_STAGES-1];
        end
    end

    assign sck_s   = sck_sync[SYNC_STAGES-1];
    assign ss_s    = ss_sync[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync[SYNC_STAGES-1];
    // SCK edges only count while the responder is selected
    assign rise    = sck_s & ~sck_d & ~ss_s;
    assign fall    = ~sck_s & sck_d & ~ss_s;
    assign ss_rise = ss_s & ~ss_d;
    assign ss_fall = ~ss_s & ss_d;
    assign load_ok = rsp_load_i & ~rsp_busy_o;

    always_comb begin
        cmd_next = spi_fbo_i ? {cmd_sr[CMD_W-2:0], mosi_s} : {mosi_s, cmd_sr[CMD_W-1:1]};
        // a load arriving on the same cycle as the WAIT fall is used immediately
        rsp_src  = load_ok ? rsp_data_i : rsp_buf;
    end

    always_ff @(posedge spi_clk_i or negedge spi_rst_i) begin
        if (!spi_rst_i) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            cmd_sr      <= '0;
            cmd_data_o  <= '0;
            cmd_valid_o <= 1'b0;
            rsp_buf     <= '0;
            rsp_sr      <= '0;
            rsp_busy_o  <= 1'b0;
            MISO        <= 1'b1;
            frame_err_o <= 1'b0;
        end else begin
            cmd_valid_o <= 1'b0;
            frame_err_o <= 1'b0;
            if (load_ok) begin
                rsp_buf    <= rsp_data_i;
                rsp_busy_o <= 1'b1;
            end
            if (ss_rise && state != IDLE) begin
                state <= IDLE;
                MISO  <= 1'b1;
                cnt   <= 8'd0;
                if (state == CMD && cnt != 8'd0)
                    frame_err_o <= 1'b1;
                if (state == WAIT || state == RESP)
                    rsp_busy_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        MISO <= 1'b1;
                        cnt  <= 8'd0;
                        if (ss_fall)
                            state <= CMD;
                    end
                    CMD: begin
                        if (rise) begin
                            cmd_sr <= cmd_next;
                            if (cnt == 8'(CMD_W - 1)) begin
                                cmd_data_o  <= cmd_next;
                                cmd_valid_o <= 1'b1;
                                cnt         <= 8'(CMD_W);
                                state       <= WAIT;
                            end else begin
                                cnt <= cnt + 8'd1;
                            end
                        end
                    end
                    WAIT: begin
                        if (fall) begin
                            if (rsp_busy_o || load_ok) begin
                                MISO   <= spi_fbo_i ? rsp_src[RSP_W-1] : rsp_src[0];
                                rsp_sr <= spi_fbo_i ? (rsp_src << 1) : (rsp_src >> 1);
                                cnt    <= 8'd1;
                                state  <= RESP;
                            end else begin
                                MISO <= 1'b1;
                            end
                        end
                    end
                    RESP: begin
                        if (fall) begin
                            if (cnt < 8'(RSP_W)) begin
                                MISO   <= spi_fbo_i ? rsp_sr[RSP_W-1] : rsp_sr[0];
                                rsp_sr <= spi_fbo_i ? (rsp_sr << 1) : (rsp_sr >> 1);
                                cnt    <= cnt + 8'd1;
                            end else begin
                                MISO       <= 1'b1;
                                rsp_busy_o <= 1'b0;
                                state      <= DONE;
                            end
                        end
                    end
                    DONE: MISO <= 1'b1;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_sta_responder.sv
// Directed bench for spi_sta_responder: drives mode-3 frames with 8-cycle SCK phases
// and compares received commands/responses with hand-computed values.
module tb_spi_sta_responder;

    logic        clk;
    logic        rst_n;
    logic        sck;
    logic        ss;
    logic        mosi;
    logic        miso;
    logic        fbo;
    logic [47:0] cmd_data;
    logic        cmd_valid;
    logic [79:0] rsp_data;
    logic        rsp_load;
    logic        rsp_busy;
    logic        frame_err;

    int n_cmp   = 0;
    int n_bad   = 0;
    int n_valid = 0;
    int n_ferr  = 0;

    spi_sta_responder #(.CMD_W(48), .RSP_W(80), .SYNC_STAGES(2)) dut (
        .spi_clk_i   (clk),
        .spi_rst_i   (rst_n),
        .SCK         (sck),
        .SS          (ss),
        .MOSI        (mosi),
        .MISO        (miso),
        .spi_fbo_i   (fbo),
        .cmd_data_o  (cmd_data),
        .cmd_valid_o (cmd_valid),
        .rsp_data_i  (rsp_data),
        .rsp_load_i  (rsp_load),
        .rsp_busy_o  (rsp_busy),
        .frame_err_o (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_valid) n_valid++;
        if (frame_err) n_ferr++;
    end

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // one SCK period: fall + drive MOSI, sample MISO before rise
    task automatic sbit(input logic b, output logic r);
        sck  = 1'b0;
        mosi = b;
        repeat (8) @(negedge clk);
        r   = miso;
        sck = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [47:0] c, output logic ones);
        logic r;
        ones = 1'b1;
        for (int i = 0; i < 48; i++) begin
            sbit(fbo ? c[47-i] : c[i], r);
            ones = ones & r;
        end
    endtask

    task automatic recv(input int n, output logic [79:0] w);
        logic r;
        w = '0;
        for (int i = 0; i < n; i++) begin
            sbit(1'b0, r);
            if (fbo) w = {w[78:0], r};
            else     w[i] = r;
        end
    endtask

    task automatic load_rsp(input logic [79:0] d);
        rsp_data = d;
        rsp_load = 1'b1;
        @(negedge clk);
        rsp_load = 1'b0;
        @(negedge clk);
    endtask

    task automatic ss_low();
        ss = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic ss_high();
        ss = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    logic [79:0] w;
    logic        ones;
    logic        r;

    initial begin
        rst_n    = 1'b0;
        sck      = 1'b1;
        ss       = 1'b1;
        mosi     = 1'b0;
        fbo      = 1'b1;
        rsp_load = 1'b0;
        rsp_data = '0;
        repeat (3) @(negedge clk);
        check("rst_miso", 80'(miso), 80'h1);
        check("rst_cmd_data", 80'(cmd_data), 80'h0);
        check("rst_cmd_valid", 80'(cmd_valid), 80'h0);
        check("rst_busy", 80'(rsp_busy), 80'h0);
        check("rst_frame_err", 80'(frame_err), 80'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // MSB-first command, then response loaded during WAIT filler
        fbo = 1'b1;
        ss_low();
        send_cmd(48'h4000_0000_0095, ones);
        check("msb_cmd_miso_idle", 80'(ones), 80'h1);
        check("msb_cmd_data", 80'(cmd_data), 80'h4000_0000_0095);
        check("msb_valid_count", 80'(n_valid), 80'd1);
        check("busy_before_load", 80'(rsp_busy), 80'h0);
        recv(4, w);
        check("filler_before_load", w, 80'hF);
        load_rsp(80'h1);
        check("busy_after_load", 80'(rsp_busy), 80'h1);
        recv(80, w);
        check("msb_rsp_word", w, 80'h1);
        recv(4, w);
        check("msb_rsp_trailing", w, 80'hF);
        check("busy_after_rsp", 80'(rsp_busy), 80'h0);
        ss_high();
        check("no_frame_err_full", 80'(n_ferr), 80'd0);

        // LSB-first round trip with preloaded response; second load ignored
        fbo = 1'b0;
        load_rsp(80'h1234_5678_9ABC_DEF0_1234);
        check("busy_preload", 80'(rsp_busy), 80'h1);
        load_rsp(80'hFFFF_0000_FFFF_0000_FFFF);
        check("busy_second_load", 80'(rsp_busy), 80'h1);
        ss_low();
        send_cmd(48'hA5A5_0000_5A5A, ones);
        check("lsb_cmd_data", 80'(cmd_data), 80'hA5A5_0000_5A5A);
        recv(80, w);
        check("lsb_rsp_word", w, 80'h1234_5678_9ABC_DEF0_1234);
        recv(1, w);
        check("lsb_rsp_trailing", w, 80'h1);
        check("lsb_busy_after", 80'(rsp_busy), 80'h0);
        check("lsb_valid_count", 80'(n_valid), 80'd2);
        ss_high();

        // abort after 20 command bits
        fbo = 1'b1;
        ss_low();
        for (int i = 0; i < 20; i++) sbit(1'b1, r);
        ss_high();
        check("abort_frame_err", 80'(n_ferr), 80'd1);
        check("abort_cmd_kept", 80'(cmd_data), 80'hA5A5_0000_5A5A);
        check("abort_no_valid", 80'(n_valid), 80'd2);

        // next full frame, no response: 16 filler ones
        ss_low();
        send_cmd(48'h1234_5678_9ABC, ones);
        check("after_abort_cmd", 80'(cmd_data), 80'h1234_5678_9ABC);
        check("after_abort_valid", 80'(n_valid), 80'd3);
        recv(16, w);
        check("filler_16", w, 80'hFFFF);
        check("filler_busy", 80'(rsp_busy), 80'h0);
        ss_high();
        check("after_abort_ferr", 80'(n_ferr), 80'd1);

        // reset in the middle of a response
        load_rsp(80'h0);
        ss_low();
        send_cmd(48'h0F0F_0F0F_0F0F, ones);
        recv(10, w);
        check("resp_zeros", w, 80'h0);
        rst_n = 1'b0;
        #1;
        check("midrst_miso", 80'(miso), 80'h1);
        check("midrst_busy", 80'(rsp_busy), 80'h0);
        check("midrst_cmd_data", 80'(cmd_data), 80'h0);
        ss = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        ss_low();
        send_cmd(48'hDEAD_BEEF_CAFE, ones);
        check("post_rst_cmd", 80'(cmd_data), 80'hDEAD_BEEF_CAFE);
        check("post_rst_valid", 80'(n_valid), 80'd5);
        recv(8, w);
        check("post_rst_filler", w, 80'hFF);
        ss_high();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
